mcdf_arbiter: RTL and testbench

Packet-level arbiter of the multi-channel data formatter. It sits between the per-channel slave FIFOs and the formatter. It selects one enabled, requesting channel by priority, breaking ties with round-robin, and locks the grant for a full packet. It then forwards that channel's words to the formatter under a valid/ack handshake.

---
 rtl/mcdf_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mcdf_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: packet-level arbiter between the per-channel slave FIFOs and
// the formatter. It picks the highest-priority enabled, requesting channel,
// breaking ties round-robin. It then locks that grant for a whole packet and
// streams the channel's words to the formatter under a valid/ack handshake.
module mcdf_arbiter #(
    parameter int NCH = 3,
    parameter int DW  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NCH-1:0]      slv_en_i,
    input  logic [NCH-1:0]      slv_req_i,
    input  logic [2*NCH-1:0]    slv_prio_i,
    input  logic [3*NCH-1:0]    slv_len_i,
    input  logic [NCH-1:0]      slv_val_i,
    input  logic [DW*NCH-1:0]   slv_data_i,
    output logic [NCH-1:0]      a2s_ack_o,
    input  logic                f2a_id_req_i,
    input  logic                f2a_ack_i,
    output logic                a2f_val_o,
    output logic [DW-1:0]       a2f_data_o,
    output logic [1:0]          a2f_id_o,
    output logic [5:0]          a2f_pkglen_o,
    output logic [1:0]          a2f_pri_o,
    output logic                busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_rr_ptr;
    logic [5:0]      r_cnt;
    logic [1:0]      r_id;
    logic [1:0]      r_pri;
    logic [5:0]      r_pkglen;

    logic [NCH-1:0]  w_elig;
    logic            w_win_found;
    logic [1:0]      w_win_id;
    logic [1:0]      w_win_pri;
    logic [5:0]      w_win_len;
    logic [2:0]      w_win_dist;
    logic [2:0]      w_dist;
    logic [1:0]      w_pri;

    logic            w_sel_val;
    logic [DW-1:0]   w_sel_data;
    logic            w_grant;
    logic            w_xfer;
    logic            w_last;

    function automatic logic [5:0] f_decode_len(input logic [2:0] code);
        case (code)
            3'd0:    return 6'd4;
            3'd1:    return 6'd8;
            3'd2:    return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    assign w_elig = slv_en_i & slv_req_i;
    assign busy_o = (r_state == ST_XFER);

    assign a2f_id_o     = r_id;
    assign a2f_pri_o    = r_pri;
    assign a2f_pkglen_o = r_pkglen;

    // Winner selection: lowest priority value wins; on a tie the channel
    // closest to rr_ptr in upward (wrapping) scan order wins. Expressing the
    // scan as a distance key keeps every field select constant-indexed.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_win_pri   = '1;
        w_win_len   = '0;
        w_win_dist  = '1;
        w_dist      = '0;
        w_pri       = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (3'(k) >= {1'b0, r_rr_ptr})
                w_dist = 3'(k) - {1'b0, r_rr_ptr};
            else
                w_dist = 3'(k) + 3'(NCH) - {1'b0, r_rr_ptr};
            w_pri = slv_prio_i[2*k +: 2];
            if (w_elig[k] && (!w_win_found || (w_pri < w_win_pri) ||
                              ((w_pri == w_win_pri) && (w_dist < w_win_dist)))) begin
                w_win_found = 1'b1;
                w_win_id    = 2'(k);
                w_win_pri   = w_pri;
                w_win_len   = f_decode_len(slv_len_i[3*k +: 3]);
                w_win_dist  = w_dist;
            end
        end
    end

    // Head-of-FIFO mux for the currently granted channel.
    always_comb begin
        w_sel_val  = 1'b0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (r_id == 2'(k)) begin
                w_sel_val  = slv_val_i[k];
                w_sel_data = slv_data_i[DW*k +: DW];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state and combinational handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        a2f_val_o   = 1'b0;
        a2f_data_o  = '0;
        a2s_ack_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (f2a_id_req_i && w_win_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                a2f_val_o  = w_sel_val;
                a2f_data_o = w_sel_val ? w_sel_data : '0;
                if (w_sel_val && f2a_ack_i) begin
                    w_xfer = 1'b1;
                    for (int unsigned k = 0; k < NCH; k++)
                        a2s_ack_o[k] = (r_id == 2'(k));
                    if (r_cnt == 6'd1) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant capture, word counter and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_pri    <= '0;
            r_pkglen <= '0;
        end else if (w_grant) begin
            r_id     <= w_win_id;
            r_pri    <= w_win_pri;
            r_pkglen <= w_win_len;
            r_cnt    <= w_win_len;
        end else if (w_xfer && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 6'd1;
            if (w_last)
                r_rr_ptr <= (r_id == 2'(NCH-1)) ? 2'd0 : r_id + 2'd1;
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed testbench for mcdf_arbiter: priority, round-robin, back-pressure,
// enable masking and reset-during-packet scenarios with hand-derived results.
module tb_mcdf_arbiter;

    localparam int NCH = 3;
    localparam int DW  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NCH-1:0]    slv_en_i;
    logic [NCH-1:0]    slv_req_i;
    logic [2*NCH-1:0]  slv_prio_i;
    logic [3*NCH-1:0]  slv_len_i;
    logic [NCH-1:0]    slv_val_i;
    logic [DW*NCH-1:0] slv_data_i;
    logic [NCH-1:0]    a2s_ack_o;
    logic              f2a_id_req_i;
    logic              f2a_ack_i;
    logic              a2f_val_o;
    logic [DW-1:0]     a2f_data_o;
    logic [1:0]        a2f_id_o;
    logic [5:0]        a2f_pkglen_o;
    logic [1:0]        a2f_pri_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int head [NCH];
    int mode;
    logic [NCH-1:0]   pend_en, pend_req;
    logic [2*NCH-1:0] pend_prio;
    logic [NCH-1:0]   obs_ack;

    mcdf_arbiter #(.NCH(NCH), .DW(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .slv_en_i     (slv_en_i),
        .slv_req_i    (slv_req_i),
        .slv_prio_i   (slv_prio_i),
        .slv_len_i    (slv_len_i),
        .slv_val_i    (slv_val_i),
        .slv_data_i   (slv_data_i),
        .a2s_ack_o    (a2s_ack_o),
        .f2a_id_req_i (f2a_id_req_i),
        .f2a_ack_i    (f2a_ack_i),
        .a2f_val_o    (a2f_val_o),
        .a2f_data_o   (a2f_data_o),
        .a2f_id_o     (a2f_id_o),
        .a2f_pkglen_o (a2f_pkglen_o),
        .a2f_pri_o    (a2f_pri_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int ch, input int n);
        return {8'(8'hA0 + ch), 24'(n)};
    endfunction

    task automatic drive_data();
        for (int k = 0; k < NCH; k++)
            slv_data_i[DW*k +: DW] = word(k, head[k]);
    endtask

    // One clock: note pops seen this cycle, advance the modelled FIFO heads.
    task automatic step();
        obs_ack = a2s_ack_o;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < NCH; k++)
            if (obs_ack[k]) head[k]++;
        drive_data();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_val"},  a2f_val_o, 0);
        check({tag, "_ack"},  a2s_ack_o, 0);
        check({tag, "_data"}, a2f_data_o, 0);
        check({tag, "_id"},   a2f_id_o, 0);
        check({tag, "_len"},  a2f_pkglen_o, 0);
        check({tag, "_pri"},  a2f_pri_o, 0);
    endtask

    // Called in the IDLE cycle where the grant is expected to be decided.
    task automatic run_pkt(input int exp_id, input int exp_len, input int exp_pri, input int stop_at);
        int nxfer, ncyc, base;
        logic exp_val;
        logic [NCH-1:0] exp_ack;
        check("idle_busy", busy_o, 0);
        check("idle_val",  a2f_val_o, 0);
        check("idle_ack",  a2s_ack_o, 0);
        check("idle_data", a2f_data_o, 0);
        step();
        check("grant_busy", busy_o, 1);
        check("grant_id",   a2f_id_o, exp_id);
        check("grant_len",  a2f_pkglen_o, exp_len);
        check("grant_pri",  a2f_pri_o, exp_pri);
        base  = head[exp_id];
        nxfer = 0;
        ncyc  = 0;
        while (busy_o && ncyc < 200 && !(stop_at != 0 && nxfer == stop_at)) begin
            case (mode)
                1: begin
                    f2a_ack_i    = (ncyc % 2 == 0);
                    slv_val_i[0] = !(ncyc >= 3 && ncyc < 6);
                end
                2: if (nxfer >= 5) slv_en_i[1] = 1'b0;
                4: if (ncyc == 0) begin
                    slv_en_i   = pend_en;
                    slv_req_i  = pend_req;
                    slv_prio_i = pend_prio;
                end
                default: ;
            endcase
            #1;
            exp_val = slv_val_i[exp_id];
            check("xfer_val",  a2f_val_o, exp_val);
            check("xfer_data", a2f_data_o, exp_val ? word(exp_id, base + nxfer) : '0);
            exp_ack = '0;
            if (exp_val && f2a_ack_i) exp_ack[exp_id] = 1'b1;
            check("xfer_ack",  a2s_ack_o, exp_ack);
            check("xfer_id_hold", a2f_id_o, exp_id);
            if (exp_val && f2a_ack_i) nxfer++;
            ncyc++;
            step();
        end
        if (stop_at == 0) begin
            check("pkt_words", nxfer, exp_len);
            check("pkt_done",  busy_o, 0);
            if (mode != 1) check("pkt_cycles", ncyc, exp_len);
            check("post_id_hold",  a2f_id_o, exp_id);
            check("post_len_hold", a2f_pkglen_o, exp_len);
        end
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) head[k] = 0;
        mode         = 0;
        rst_i        = 1'b1;
        slv_en_i     = '1;
        slv_req_i    = '1;
        slv_prio_i   = '0;
        slv_len_i    = '0;
        slv_val_i    = '1;
        f2a_id_req_i = 1'b1;
        f2a_ack_i    = 1'b1;
        drive_data();
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");

        slv_en_i     = '0;
        f2a_id_req_i = 1'b0;
        rst_i        = 1'b0;
        step();
        check("no_req_busy", busy_o, 0);

        // Priority: ch0 prio 2, ch2 prio 1. ch2 drops its request mid-packet.
        f2a_id_req_i = 1'b1;
        slv_en_i     = 3'b101;
        slv_req_i    = 3'b101;
        slv_prio_i   = {2'd1, 2'd0, 2'd2};
        pend_en      = 3'b101;
        pend_req     = 3'b001;
        pend_prio    = {2'd1, 2'd0, 2'd2};
        mode         = 4;
        #1;
        run_pkt(2, 4, 1, 0);
        mode = 0;
        run_pkt(0, 4, 2, 0);

        // Single channel ch1; rr_ptr then 2, so a ch0/ch2 tie goes to ch2.
        slv_en_i   = 3'b010;
        slv_req_i  = 3'b010;
        slv_prio_i = '0;
        pend_en    = 3'b101;
        pend_req   = 3'b101;
        pend_prio  = '0;
        mode       = 4;
        #1;
        run_pkt(1, 4, 0, 0);
        mode = 0;
        run_pkt(2, 4, 0, 0);

        // Round-robin with all channels at equal priority.
        slv_en_i  = '1;
        slv_req_i = '1;
        #1;
        run_pkt(0, 4, 0, 0);
        run_pkt(1, 4, 0, 0);
        run_pkt(2, 4, 0, 0);
        run_pkt(0, 4, 0, 0);
        run_pkt(1, 4, 0, 0);

        // Back-pressure on ch0, 8-word packet.
        slv_en_i  = 3'b001;
        slv_req_i = 3'b001;
        slv_len_i = {3'd0, 3'd0, 3'd1};
        mode      = 1;
        #1;
        run_pkt(0, 8, 0, 0);
        mode      = 0;
        f2a_ack_i = 1'b1;
        slv_val_i = '1;

        // Enable masking: ch0 disabled at prio 0; ch1 loses enable mid-packet.
        slv_en_i   = 3'b010;
        slv_req_i  = 3'b011;
        slv_prio_i = {2'd0, 2'd3, 2'd0};
        slv_len_i  = {3'd0, 3'd7, 3'd0};
        mode       = 2;
        #1;
        run_pkt(1, 32, 3, 0);
        mode = 0;
        for (int i = 0; i < 3; i++) begin
            check("en_idle_busy", busy_o, 0);
            check("en_idle_ack", a2s_ack_o, 0);
            step();
        end

        // Reset after 3 of 16 words on ch2 (rr_ptr is 2 here).
        slv_en_i   = 3'b100;
        slv_req_i  = 3'b100;
        slv_prio_i = '0;
        slv_len_i  = {3'd2, 3'd0, 3'd0};
        #1;
        run_pkt(2, 16, 0, 3);
        check("pre_rst_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        step();
        step();
        check("rst_hold_ack", a2s_ack_o, 0);
        check("rst_hold_busy", busy_o, 0);
        rst_i     = 1'b0;
        slv_en_i  = '1;
        slv_req_i = '1;
        slv_len_i = '0;
        #1;
        run_pkt(0, 4, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
